// File: rtl/dmem_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// dmem_sram_ctrl_pkg : shared CPU defines (memory op codes, data-port states)
// Revision 1.0
// ============================================================================
package dmem_sram_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LBU = 6'd2;
  localparam logic [5:0] OP_LH  = 6'd3;
  localparam logic [5:0] OP_LHU = 6'd4;
  localparam logic [5:0] OP_LW  = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2
  } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_ext.sv
`default_nettype none
// ============================================================================
// mem_lane_ext : byte-lane steering (store align/strobe, load shift/extend)
// Revision 1.0
// ============================================================================
module mem_lane_ext
  import dmem_sram_ctrl_pkg::*;
(
  input  logic [5:0]  st_op,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [1:0]  st_size,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata_al,
  input  logic [5:0]  ld_op,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] w_shifted;

  always_comb begin
    st_size     = 2'd2;
    st_wstrb    = 4'h0;
    st_wdata_al = st_wdata;
    case (st_op)
      OP_LB, OP_LBU: st_size = 2'd0;
      OP_LH, OP_LHU: st_size = 2'd1;
      OP_SB: begin
        st_size     = 2'd0;
        st_wstrb    = 4'b0001 << st_lo;
        st_wdata_al = {4{st_wdata[7:0]}};
      end
      OP_SH: begin
        st_size     = 2'd1;
        st_wstrb    = 4'b0011 << st_lo;
        st_wdata_al = {2{st_wdata[15:0]}};
      end
      OP_SW: st_wstrb = 4'hF;
      default: ;
    endcase
  end

  assign w_shifted = ld_raw >> {ld_lo, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    case (ld_op)
      OP_LB:  ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      OP_LBU: ld_data = {24'h0, w_shifted[7:0]};
      OP_LH:  ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      OP_LHU: ld_data = {16'h0, w_shifted[15:0]};
      OP_LW:  ld_data = w_shifted;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_sram_ctrl : E-stage data port to an SRAM-like bus, one access in flight
// Revision 1.0
// ============================================================================
module dmem_sram_ctrl
  import dmem_sram_ctrl_pkg::*;
#(
  parameter int PHYS_MAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        E_mem_en,
  input  logic        E_mem_wen,
  input  logic [5:0]  E_mem_op,
  input  logic [31:0] E_mem_addr,
  input  logic [31:0] E_mem_wdata,
  input  logic        E_flush,
  output logic        d_stall,
  output logic [31:0] M_mem_rdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  dmem_state_t r_state, w_next;

  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [5:0]  r_op;
  logic        r_cancel;
  logic [31:0] r_rdata;
  logic [5:0]  r_ld_op;
  logic [1:0]  r_ld_lo;

  logic        w_issue;
  logic        w_capture;
  logic [31:0] w_e_addr;
  logic [1:0]  w_e_size;
  logic [3:0]  w_e_wstrb;
  logic [31:0] w_e_wdata;

  assign w_issue  = E_mem_en & ~E_flush;
  assign w_e_addr = (PHYS_MAP != 0) ? {3'b000, E_mem_addr[28:0]} : E_mem_addr;

  // Extension uses the op/offset frozen with the captured data, so a flushed
  // or store access never disturbs the value seen by the M stage.
  mem_lane_ext u_lane (
    .st_op       (E_mem_op),
    .st_lo       (E_mem_addr[1:0]),
    .st_wdata    (E_mem_wdata),
    .st_size     (w_e_size),
    .st_wstrb    (w_e_wstrb),
    .st_wdata_al (w_e_wdata),
    .ld_op       (r_ld_op),
    .ld_lo       (r_ld_lo),
    .ld_raw      (r_rdata),
    .ld_data     (M_mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    data_req   = 1'b0;
    data_wr    = r_wr;
    data_size  = r_size;
    data_addr  = r_addr;
    data_wdata = r_wdata;
    data_wstrb = r_wstrb;
    d_stall    = 1'b0;
    case (r_state)
      IDLE: begin
        data_req   = w_issue;
        data_wr    = E_mem_wen;
        data_size  = w_e_size;
        data_addr  = w_e_addr;
        data_wdata = w_e_wdata;
        data_wstrb = w_e_wstrb;
        d_stall    = w_issue;
        if (w_issue) w_next = data_addr_ok ? WAIT_DATA : WAIT_ADDR;
      end
      WAIT_ADDR: begin
        data_req = 1'b1;
        d_stall  = 1'b1;
        if (data_addr_ok) w_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        d_stall = ~data_data_ok;
        if (data_data_ok) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_capture = (r_state == WAIT_DATA) & data_data_ok & ~r_wr & ~r_cancel & ~E_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_wstrb  <= 4'h0;
      r_op     <= 6'h0;
      r_cancel <= 1'b0;
      r_rdata  <= 32'h0;
      r_ld_op  <= 6'h0;
      r_ld_lo  <= 2'd0;
    end else begin
      if ((r_state == IDLE) && w_issue) begin
        r_wr     <= E_mem_wen;
        r_size   <= w_e_size;
        r_addr   <= w_e_addr;
        r_wdata  <= w_e_wdata;
        r_wstrb  <= w_e_wstrb;
        r_op     <= E_mem_op;
        r_cancel <= 1'b0;
      end else if ((r_state != IDLE) && E_flush) begin
        r_cancel <= 1'b1;
      end
      if (w_capture) begin
        r_rdata <= data_rdata;
        r_ld_op <= r_op;
        r_ld_lo <= r_addr[1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dmem_sram_ctrl : directed + randomized checks against a behavioural model
// Revision 1.0
// ============================================================================
module tb_dmem_sram_ctrl;
  import dmem_sram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        E_mem_en, E_mem_wen, E_flush;
  logic [5:0]  E_mem_op;
  logic [31:0] E_mem_addr, E_mem_wdata;
  logic        d_stall;
  logic [31:0] M_mem_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  dmem_sram_ctrl #(.PHYS_MAP(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .E_mem_en     (E_mem_en),
    .E_mem_wen    (E_mem_wen),
    .E_mem_op     (E_mem_op),
    .E_mem_addr   (E_mem_addr),
    .E_mem_wdata  (E_mem_wdata),
    .E_flush      (E_flush),
    .d_stall      (d_stall),
    .M_mem_rdata  (M_mem_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic int op_bytes(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_size(input logic [5:0] op);
    return (op_bytes(op) == 1) ? 32'd0 : (op_bytes(op) == 2) ? 32'd1 : 32'd2;
  endfunction

  function automatic logic [31:0] ref_wstrb(input logic [5:0] op, input logic [31:0] addr);
    int m;
    if (!is_store(op)) return 32'd0;
    m = ((1 << op_bytes(op)) - 1) << (addr % 4);
    return 32'(m % 16);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] wd);
    if (op_bytes(op) == 1) return (wd % 256) * 32'h0101_0101;
    if (op_bytes(op) == 2) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (addr % 4));
    case (op)
      OP_LB:  begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      OP_LBU: v = v % 256;
      OP_LH:  begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      OP_LHU: v = v % 65536;
      default: ;
    endcase
    return v;
  endfunction

  // One complete access: issue at cycle 0, addr_ok at cycle a_dly, data_ok
  // d_dly cycles later; optional one-cycle E_flush at cycle flush_at (>0).
  task automatic run_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            input int a_dly, input int d_dly, input logic [31:0] rd, input int flush_at);
    int last;
    int stalls;
    bit cancelled;
    last = a_dly + d_dly;
    stalls = 0;
    cancelled = 0;
    for (int c = 0; c <= last; c++) begin
      E_mem_en     = (c == 0);
      E_mem_op     = (c == 0) ? op : 6'($urandom_range(1, 8));
      E_mem_wen    = (c == 0) ? is_store(op) : 1'($urandom);
      E_mem_addr   = (c == 0) ? addr : $urandom;
      E_mem_wdata  = (c == 0) ? wd : $urandom;
      E_flush      = (c > 0) && (c == flush_at);
      data_addr_ok = (c == a_dly);
      data_data_ok = (c == last);
      data_rdata   = (c == last) ? rd : $urandom;
      if (E_flush) cancelled = 1;
      @(negedge clk);
      if (d_stall) stalls++;
      check_eq("m_hold", M_mem_rdata, model_rdata);
      if (c <= a_dly) begin
        check_eq("req", 32'(data_req), 32'd1);
        check_eq("addr", data_addr, addr & 32'h1FFF_FFFF);
        check_eq("wr", 32'(data_wr), 32'(is_store(op)));
        check_eq("size", 32'(data_size), ref_size(op));
        check_eq("wstrb", 32'(data_wstrb), ref_wstrb(op, addr));
        if (is_store(op)) check_eq("wdata", data_wdata, ref_wdata(op, wd));
      end else begin
        check_eq("req_wd", 32'(data_req), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    E_mem_en = 0; E_flush = 0; data_addr_ok = 0; data_data_ok = 0;
    if (!is_store(op) && !cancelled) model_rdata = ref_load(op, addr, rd);
    @(negedge clk);
    check_eq("stall_cnt", 32'(stalls), 32'(last));
    check_eq("stall_idle", 32'(d_stall), 32'd0);
    check_eq("m_rdata", M_mem_rdata, model_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]  ops [8];
    logic [5:0]  op;
    logic [31:0] addr;
    int          a_dly, d_dly, fl;
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

    rst = 1; E_mem_en = 0; E_mem_wen = 0; E_mem_op = OP_LW; E_mem_addr = 0;
    E_mem_wdata = 0; E_flush = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    model_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 32'(d_stall), 32'd0);
    check_eq("rst_req", 32'(data_req), 32'd0);
    check_eq("rst_mdata", M_mem_rdata, 32'd0);
    E_mem_en = 1;
    #1;
    check_eq("rst_req_comb", 32'(data_req), 32'd1);
    E_mem_en = 0;
    @(posedge clk);
    #1;
    rst = 0;

    // LW through kseg0, then byte loads with sign/zero extension
    run_access(OP_LW,  32'h8000_0010, 32'h0, 0, 3, 32'h1234_5678, -1);
    check_eq("lw_value", M_mem_rdata, 32'h1234_5678);
    run_access(OP_LB,  32'hA000_0003, 32'h0, 0, 2, 32'h80FF_FFFF, -1);
    check_eq("lb_value", M_mem_rdata, 32'hFFFF_FF80);
    run_access(OP_LBU, 32'hA000_0003, 32'h0, 1, 1, 32'h80FF_FFFF, -1);
    check_eq("lbu_value", M_mem_rdata, 32'h0000_0080);
    // Store with delayed address acceptance, registered fields must hold
    run_access(OP_SH,  32'h0000_1002, 32'h0000_BEEF, 3, 1, 32'hDEAD_0000, -1);
    check_eq("sh_keeps", M_mem_rdata, 32'h0000_0080);
    // Flushed load in WAIT_DATA: value must not change, next load clean
    run_access(OP_LW,  32'h0000_2000, 32'h0, 0, 3, 32'hCAFE_F00D, 1);
    check_eq("flush_keep", M_mem_rdata, 32'h0000_0080);
    run_access(OP_LHU, 32'h0000_2002, 32'h0, 0, 1, 32'hABCD_1234, -1);
    check_eq("after_flush", M_mem_rdata, 32'h0000_ABCD);

    // Flush in the issue cycle suppresses the request entirely
    E_mem_en = 1; E_mem_op = OP_LW; E_mem_wen = 0; E_mem_addr = 32'h40; E_flush = 1; data_addr_ok = 1;
    @(negedge clk);
    check_eq("flush_issue_req", 32'(data_req), 32'd0);
    check_eq("flush_issue_stall", 32'(d_stall), 32'd0);
    @(posedge clk); #1;
    E_mem_en = 0; E_flush = 0; data_addr_ok = 0;
    @(negedge clk);
    check_eq("flush_issue_idle", 32'(d_stall), 32'd0);
    @(posedge clk); #1;

    // Reset during WAIT_DATA, then a stray data_ok
    E_mem_en = 1; E_mem_op = OP_LW; E_mem_wen = 0; E_mem_addr = 32'h80; data_addr_ok = 1;
    @(posedge clk); #1;
    E_mem_en = 0; data_addr_ok = 0;
    @(negedge clk);
    check_eq("wd_stall", 32'(d_stall), 32'd1);
    #1 rst = 1;
    #1;
    check_eq("rst_mid_stall", 32'(d_stall), 32'd0);
    @(posedge clk); #1;
    rst = 0; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    model_rdata = 0;
    @(negedge clk);
    check_eq("stray_stall", 32'(d_stall), 32'd0);
    check_eq("stray_req", 32'(data_req), 32'd0);
    @(posedge clk); #1;
    data_data_ok = 0;
    @(negedge clk);
    check_eq("stray_nocap", M_mem_rdata, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 7)];
      addr = $urandom;
      addr = addr & ~32'(op_bytes(op) - 1);
      a_dly = $urandom_range(0, 3);
      d_dly = $urandom_range(1, 3);
      fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, a_dly + d_dly)) : -1;
      run_access(op, addr, $urandom, a_dly, d_dly, $urandom, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
